usr_serial_deserializer: RTL and testbench

Serial-to-parallel receive stage placed directly downstream of the universal shift register. It consumes the bit stream on the register's s_right output, detects a start bit, and assembles DATA_W data bits into a word. The word is presented on a valid/ready output port backed by a single-entry holding register, with sticky overrun detection.

---
 rtl/usr_serial_deserializer_pkg.sv | 24 ++
 rtl/usr_serial_deserializer_if.sv | 40 ++++
 rtl/usr_serial_deserializer_out_slot.sv | 42 ++++
 rtl/usr_serial_deserializer.sv | 104 ++++++++++
 tb/tb_usr_serial_deserializer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/usr_serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer: FSM encoding, default width,
// and the counter-width helper.
package usr_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t PARITY = 2'd2;
    localparam state_t DONE   = 2'd3;

    localparam int DATA_W_DEFAULT = 4;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/usr_serial_deserializer_if.sv
// Bundled serial input, word output and status signals of the deserializer.
// parity_err exists only when USR_DESER_PARITY_CHECK_EN is defined.
interface usr_serial_deserializer_if
    import usr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              s_in;
    logic              s_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              overrun;
    logic              ovr_clr;
    state_t            fsm_state;
`ifdef USR_DESER_PARITY_CHECK_EN
    logic              parity_err;
`endif

    // Handshake: s_in is consumed only on cycles with s_valid=1 (no back-pressure);
    // a word transfers on every rising edge where m_valid=1 and m_ready=1, and
    // m_data is stable while m_valid=1 and not yet accepted.
    modport slave (
        input  s_in, s_valid, m_ready, ovr_clr,
        output m_data, m_valid, busy, overrun, fsm_state
`ifdef USR_DESER_PARITY_CHECK_EN
        , output parity_err
`endif
    );

    modport master (
        output s_in, s_valid, m_ready, ovr_clr,
        input  m_data, m_valid, busy, overrun, fsm_state
`ifdef USR_DESER_PARITY_CHECK_EN
        , input parity_err
`endif
    );

endinterface

// File: rtl/usr_serial_deserializer_out_slot.sv
// Single-entry valid/ready holding register with a sticky overrun flag.
module usr_out_slot
    import usr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              m_ready,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              overrun
);

    logic accept;
    logic drop;

    // A word freed by the downstream in the same cycle makes room for the new one.
    assign accept = load && (!m_valid || m_ready);
    assign drop   = load && m_valid && !m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                m_data  <= word;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/usr_serial_deserializer.sv
// Start-bit framed serial-to-parallel receiver feeding a one-word output slot.
// Define USR_DESER_PARITY_CHECK_EN to receive and check a trailing even-parity bit.
module usr_serial_deserializer
    import usr_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    usr_serial_deserializer_if.slave   bus
);

    localparam int CNT_W = clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              start;
    logic              take_bit;
    logic              load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.s_valid && bus.s_in) state_nxt = SHIFT;
            SHIFT:  if (bus.s_valid && (cnt == LAST_IDX)) begin
`ifdef USR_DESER_PARITY_CHECK_EN
                        state_nxt = PARITY;
`else
                        state_nxt = DONE;
`endif
                    end
            PARITY: if (bus.s_valid) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start    = (state == IDLE) && bus.s_valid && bus.s_in;
        take_bit = (state == SHIFT) && bus.s_valid;
        load     = (state == DONE);
        bus.busy = (state != IDLE);
    end

    assign bus.fsm_state = state;
    // Bits land by position rather than shifting, so every frame overwrites all of shreg.
    assign bit_idx = MSB_FIRST ? (LAST_IDX - cnt) : cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (take_bit) begin
            shreg[bit_idx] <= bus.s_in;
            cnt            <= cnt + CNT_W'(1);
        end
    end

    usr_out_slot #(.DATA_W(DATA_W)) u_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .word    (shreg),
        .m_ready (bus.m_ready),
        .ovr_clr (bus.ovr_clr),
        .m_data  (bus.m_data),
        .m_valid (bus.m_valid),
        .overrun (bus.overrun)
    );

`ifdef USR_DESER_PARITY_CHECK_EN
    logic par_bit;
    logic par_err_q;
    logic accept;

    // Mirrors the slot's load decision so dropped frames leave parity_err alone.
    assign accept = load && (!bus.m_valid || bus.m_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if ((state == PARITY) && bus.s_valid) par_bit <= bus.s_in;
            if (accept) par_err_q <= ^{shreg, par_bit};
        end
    end

    assign bus.parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_usr_serial_deserializer.sv
// Self-checking bench: an LSB-first and an MSB-first instance share one stimulus
// stream; delivered words are scoreboarded against per-instance expected queues.
module tb_usr_serial_deserializer;
  import usr_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_msb_q[$];

  always #5 clk = ~clk;

  usr_serial_deserializer_if #(.DATA_W(W)) if_lsb ();
  usr_serial_deserializer_if #(.DATA_W(W)) if_msb ();

  assign if_msb.s_in    = if_lsb.s_in;
  assign if_msb.s_valid = if_lsb.s_valid;
  assign if_msb.m_ready = if_lsb.m_ready;
  assign if_msb.ovr_clr = if_lsb.ovr_clr;

  usr_serial_deserializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(rst_n), .bus(if_lsb.slave)
  );
  usr_serial_deserializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(rst_n), .bus(if_msb.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  // Present one serial bit for one clock; returns 1ns after the sampling edge.
  task automatic drive_bit(input logic b, input logic v);
    if_lsb.s_in = b;
    if_lsb.s_valid = v;
    @(posedge clk);
    #1;
    if_lsb.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Start bit, data LSB of word first, optional parity; returns in the DONE cycle.
  task automatic send_frame(input logic [W-1:0] word, input bit gap, input bit keep,
                            input bit bad_par);
    logic par_b;
    par_b = (^word) ^ bad_par;
    if (keep) begin
      exp_q.push_back(word);
      exp_msb_q.push_back(rev(word));
    end
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < W; i++) begin
      if (gap) drive_bit(~word[i], 1'b0);
      drive_bit(word[i], 1'b1);
    end
`ifdef USR_DESER_PARITY_CHECK_EN
    drive_bit(par_b, 1'b1);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && if_lsb.m_valid && if_lsb.m_ready) begin
      if (exp_q.size() == 0) check("lsb_spurious_valid", 32'(if_lsb.m_valid), 32'd0);
      else check("lsb_word", 32'(if_lsb.m_data), 32'(exp_q.pop_front()));
    end
    if (rst_n && if_msb.m_valid && if_msb.m_ready) begin
      if (exp_msb_q.size() == 0) check("msb_spurious_valid", 32'(if_msb.m_valid), 32'd0);
      else check("msb_word", 32'(if_msb.m_data), 32'(exp_msb_q.pop_front()));
    end
  end

  initial begin
    logic [W-1:0] w;
    if_lsb.s_in = 1'b0;
    if_lsb.s_valid = 1'b0;
    if_lsb.m_ready = 1'b1;
    if_lsb.ovr_clr = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(if_lsb.busy), 32'd0);
    check("rst_valid", 32'(if_lsb.m_valid), 32'd0);
    check("rst_data", 32'(if_lsb.m_data), 32'd0);
    check("rst_overrun", 32'(if_lsb.overrun), 32'd0);
    check("rst_state", 32'(if_lsb.fsm_state), 32'(IDLE));
`ifdef USR_DESER_PARITY_CHECK_EN
    check("rst_parity_err", 32'(if_lsb.parity_err), 32'd0);
`endif
    rst_n = 1'b1;

    // zeros and unqualified ones must not start a frame
    repeat (3) drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    check("idle_no_start", 32'(if_lsb.busy), 32'd0);

    // back-to-back bits, latency and one-cycle valid
    send_frame(4'b1010, 1'b0, 1'b1, 1'b0);
    check("done_state", 32'(if_lsb.fsm_state), 32'(DONE));
    check("done_busy", 32'(if_lsb.busy), 32'd1);
    check("valid_not_yet", 32'(if_lsb.m_valid), 32'd0);
    idle(1);
    check("valid_rise", 32'(if_lsb.m_valid), 32'd1);
    check("lsb_data_1010", 32'(if_lsb.m_data), 32'hA);
    check("msb_data_0101", 32'(if_msb.m_data), 32'h5);
    check("idle_after_done", 32'(if_lsb.busy), 32'd0);
    idle(1);
    check("valid_one_cycle", 32'(if_lsb.m_valid), 32'd0);

    // s_valid low on alternate cycles
    send_frame(4'b1010, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("gap_data", 32'(if_lsb.m_data), 32'hA);
    idle(1);

    // start bit presented in DONE is ignored
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    check("done_ignores_start", 32'(if_lsb.busy), 32'd0);
    idle(2);

    // overrun with a full slot, then clear and drain
    if_lsb.m_ready = 1'b0;
    send_frame(4'b1010, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_frame(4'b1101, 1'b0, 1'b0, 1'b0);
    check("ovr_not_yet", 32'(if_lsb.overrun), 32'd0);
    idle(1);
    check("ovr_set", 32'(if_lsb.overrun), 32'd1);
    check("ovr_keeps_old", 32'(if_lsb.m_data), 32'hA);
    idle(2);
    check("ovr_sticky", 32'(if_lsb.overrun), 32'd1);
    if_lsb.ovr_clr = 1'b1;
    idle(1);
    if_lsb.ovr_clr = 1'b0;
    check("ovr_cleared", 32'(if_lsb.overrun), 32'd0);
    if_lsb.m_ready = 1'b1;
    idle(1);
    check("ovr_drained", 32'(if_lsb.m_valid), 32'd0);

    // overrun and ovr_clr in the same cycle: set wins
    if_lsb.m_ready = 1'b0;
    send_frame(4'b0011, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_frame(4'b0100, 1'b0, 1'b0, 1'b0);
    if_lsb.ovr_clr = 1'b1;
    idle(1);
    if_lsb.ovr_clr = 1'b0;
    check("ovr_set_wins", 32'(if_lsb.overrun), 32'd1);
    if_lsb.ovr_clr = 1'b1;
    idle(1);
    if_lsb.ovr_clr = 1'b0;
    if_lsb.m_ready = 1'b1;
    idle(1);
    check("set_wins_drained", 32'(if_lsb.m_valid), 32'd0);

    // ready raised exactly in DONE: consume old and load new together
    if_lsb.m_ready = 1'b0;
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("held_valid", 32'(if_lsb.m_valid), 32'd1);
    send_frame(4'b1001, 1'b1, 1'b1, 1'b0);
    if_lsb.m_ready = 1'b1;
    idle(1);
    check("swap_valid", 32'(if_lsb.m_valid), 32'd1);
    check("swap_data", 32'(if_lsb.m_data), 32'h9);
    check("swap_no_ovr", 32'(if_lsb.overrun), 32'd0);
    idle(1);
    check("swap_drained", 32'(if_lsb.m_valid), 32'd0);

    // reset mid-frame aborts without a partial word
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    check("mid_frame_busy", 32'(if_lsb.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(if_lsb.busy), 32'd0);
    check("abort_valid", 32'(if_lsb.m_valid), 32'd0);
    check("abort_state", 32'(if_lsb.fsm_state), 32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("post_reset_data", 32'(if_lsb.m_data), 32'hB);
    idle(1);

`ifdef USR_DESER_PARITY_CHECK_EN
    send_frame(4'b1010, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("parity_good", 32'(if_lsb.parity_err), 32'd0);
    idle(1);
    send_frame(4'b1010, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("parity_bad", 32'(if_lsb.parity_err), 32'd1);
    check("parity_bad_valid", 32'(if_lsb.m_valid), 32'd1);
    idle(1);
`endif

    // random words and gaps
    repeat (10) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      send_frame(w, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      idle($urandom_range(1, 3));
    end

    idle(4);
    check("lsb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("msb_queue_empty", 32'(exp_msb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
